// File: rtl/bcd_time_counter.sv
// Stopwatch time base: prescales clk to a TICK_HZ tick and keeps elapsed
// time as four BCD digits (SS.hh) for the 7-segment display driver.
module bcd_time_counter #(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned TICK_HZ     = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        init_regs,
   input  logic        count_enabled,
   output logic [15:0] time_bcd,
   output logic        tick,
   output logic        wrap
);

   localparam int unsigned DIV   = (TICK_HZ == 0) ? 0 : CLK_FREQ_HZ / TICK_HZ;
   localparam int unsigned PRE_W = (DIV >= 2) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   // Reject clock/tick ratios that are not an exact integer of at least 2
   if (TICK_HZ == 0 || DIV < 2 || DIV * TICK_HZ != CLK_FREQ_HZ) begin : g_bad_div
      $error("bcd_time_counter: CLK_FREQ_HZ / TICK_HZ must be exact and >= 2");
   end

   logic [PRE_W-1:0] r_pre;
   logic [15:0]      r_time_bcd;
   logic             r_tick;
   logic             r_wrap;

   logic [15:0]      w_time_inc;
   logic             w_rollover;

   // Ripple-carry BCD increment; tens-of-seconds wraps after 5
   always_comb begin
      w_time_inc = r_time_bcd;
      w_rollover = 1'b0;
      if (r_time_bcd[3:0] < 4'd9) begin
         w_time_inc[3:0] = r_time_bcd[3:0] + 4'd1;
      end else begin
         w_time_inc[3:0] = 4'd0;
         if (r_time_bcd[7:4] < 4'd9) begin
            w_time_inc[7:4] = r_time_bcd[7:4] + 4'd1;
         end else begin
            w_time_inc[7:4] = 4'd0;
            if (r_time_bcd[11:8] < 4'd9) begin
               w_time_inc[11:8] = r_time_bcd[11:8] + 4'd1;
            end else begin
               w_time_inc[11:8] = 4'd0;
               if (r_time_bcd[15:12] < 4'd5) begin
                  w_time_inc[15:12] = r_time_bcd[15:12] + 4'd1;
               end else begin
                  w_time_inc[15:12] = 4'd0;
                  w_rollover        = 1'b1;
               end
            end
         end
      end
   end

   // Partial prescaler count is held while paused so resume loses no time
   always_ff @(posedge clk) begin
      if (reset || init_regs) begin
         r_pre      <= '0;
         r_time_bcd <= 16'h0000;
         r_tick     <= 1'b0;
         r_wrap     <= 1'b0;
      end else if (count_enabled) begin
         if (r_pre == PRE_LAST) begin
            r_pre      <= '0;
            r_time_bcd <= w_time_inc;
            r_tick     <= 1'b1;
            r_wrap     <= w_rollover;
         end else begin
            r_pre  <= r_pre + PRE_W'(1);
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
         end
      end else begin
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
      end
   end

   assign time_bcd = r_time_bcd;
   assign tick     = r_tick;
   assign wrap     = r_wrap;

endmodule
